// File: rtl/alu_pkg.sv
// Shared types for the sequential ALU and its command issuer.
// Opcode encoding, legality check, response bundle and issuer states.
package alu_pkg;

  localparam int ALU_W   = 8;
  localparam int ALU_TAG = 4;

  typedef enum logic [3:0] {
    OP_ADD = 4'b0000,
    OP_SUB = 4'b0001,
    OP_AND = 4'b0010,
    OP_OR  = 4'b0011,
    OP_XOR = 4'b0100,
    OP_SLL = 4'b0101,
    OP_SRL = 4'b0110,
    OP_SRA = 4'b0111,
    OP_SLT = 4'b1000
  } alu_op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_WAIT = 2'b01,
    S_RESP = 2'b10
  } issuer_state_e;

  // Default-width response bundle as seen by a consumer.
  typedef struct packed {
    logic [ALU_W-1:0]   data;
    logic [3:0]         flags;
    logic [ALU_TAG-1:0] tag;
    logic               err;
  } rsp_t;

  function automatic logic is_legal_op(input logic [3:0] op);
    return op <= OP_SLT;
  endfunction

endpackage

// File: rtl/alu_cmd_issuer.sv
// Issues one ALU operation at a time over valid/ready and returns
// the registered ALU result, flags and tag as a response.
module alu_cmd_issuer
  import alu_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int TAG_W   = 4,
  parameter int ALU_LAT = 1,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [WIDTH-1:0] cmd_a,
  input  logic [WIDTH-1:0] cmd_b,
  input  logic [3:0]       cmd_op,
  input  logic [TAG_W-1:0] cmd_tag,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [3:0]       alu_sel,
  input  logic [WIDTH-1:0] alu_out,
  input  logic             alu_z,
  input  logic             alu_c,
  input  logic             alu_n,
  input  logic             alu_v,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic [3:0]       rsp_flags,
  output logic [TAG_W-1:0] rsp_tag,
  output logic             rsp_err,
  output logic [CNT_W-1:0] op_count,
  output logic [CNT_W-1:0] err_count
);

  issuer_state_e    state;
  logic [2:0]       cnt;
  logic [TAG_W-1:0] tag_q;
  logic             legal;
  logic             issue;
  logic             reject;
  logic             capture;

  assign legal     = is_legal_op(cmd_op);
  assign cmd_ready = (state == S_IDLE);
  assign rsp_valid = (state == S_RESP);
  assign issue     = cmd_ready && cmd_valid && legal;
  assign reject    = cmd_ready && cmd_valid && !legal;
  // Inputs reach the ALU one edge after issue, so count ALU_LAT more.
  assign capture   = (state == S_WAIT) && (cnt == 3'd0);

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      cnt       <= '0;
      tag_q     <= '0;
      alu_a     <= '0;
      alu_b     <= '0;
      alu_sel   <= 4'b0000;
      rsp_data  <= '0;
      rsp_flags <= '0;
      rsp_tag   <= '0;
      rsp_err   <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (issue) begin
            alu_a   <= cmd_a;
            alu_b   <= cmd_b;
            alu_sel <= cmd_op;
            tag_q   <= cmd_tag;
            cnt     <= 3'(ALU_LAT);
            state   <= S_WAIT;
          end else if (reject) begin
            rsp_err   <= 1'b1;
            rsp_data  <= '0;
            rsp_flags <= '0;
            rsp_tag   <= cmd_tag;
            state     <= S_RESP;
          end
        end
        S_WAIT: begin
          if (capture) begin
            rsp_data  <= alu_out;
            rsp_flags <= {alu_z, alu_c, alu_n, alu_v};
            rsp_tag   <= tag_q;
            rsp_err   <= 1'b0;
            state     <= S_RESP;
          end else begin
            cnt <= cnt - 3'd1;
          end
        end
        S_RESP: begin
          if (rsp_ready) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      op_count <= '0;
    end else if (capture && op_count != '1) begin
      op_count <= op_count + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      err_count <= '0;
    end else if (reject && err_count != '1) begin
      err_count <= err_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_alu_cmd_issuer.sv
// Scoreboard bench for alu_cmd_issuer with behavioural ALU models
// at latency 1 (default build) and latency 3 with 8-bit counters.
module tb_alu_cmd_issuer;
  import alu_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic       cmd_valid = 0, cmd_ready;
  logic [7:0] cmd_a = 0, cmd_b = 0;
  logic [3:0] cmd_op = 0, cmd_tag = 0;
  logic [7:0] alu_a, alu_b, alu_out;
  logic [3:0] alu_sel;
  logic       alu_z, alu_c, alu_n, alu_v;
  logic       rsp_valid, rsp_ready = 0, rsp_err;
  logic [7:0] rsp_data;
  logic [3:0] rsp_flags, rsp_tag;
  logic [15:0] op_count, err_count;

  logic       cmd_valid1 = 0, cmd_ready1;
  logic [7:0] cmd_a1 = 0, cmd_b1 = 0;
  logic [3:0] cmd_op1 = 0, cmd_tag1 = 0;
  logic [7:0] alu_a1, alu_b1, alu_out1;
  logic [3:0] alu_sel1;
  logic       alu_z1, alu_c1, alu_n1, alu_v1;
  logic       rsp_valid1, rsp_ready1 = 1, rsp_err1;
  logic [7:0] rsp_data1;
  logic [3:0] rsp_flags1, rsp_tag1;
  logic [7:0] op_count1, err_count1;

  int   n_vec = 0;
  int   n_bad = 0;
  rsp_t q0[$];
  rsp_t q1[$];

  // {Z,C,N,V,data}; C is borrow for SUB.
  function automatic logic [11:0] alu_ref(
    input logic [7:0] a, input logic [7:0] b, input logic [3:0] op);
    logic [8:0] s;
    logic [7:0] r;
    logic c, v;
    c = 0; v = 0; r = 0;
    case (op)
      4'd0: begin
        s = {1'b0, a} + {1'b0, b}; r = s[7:0]; c = s[8];
        v = (a[7] == b[7]) && (r[7] != a[7]);
      end
      4'd1: begin
        r = a - b; c = (a < b);
        v = (a[7] != b[7]) && (r[7] != a[7]);
      end
      4'd2: r = a & b;
      4'd3: r = a | b;
      4'd4: r = a ^ b;
      4'd5: r = a << b[2:0];
      4'd6: r = a >> b[2:0];
      4'd7: r = $signed(a) >>> b[2:0];
      4'd8: r = {7'd0, $signed(a) < $signed(b)};
      default: r = 0;
    endcase
    return {r == 8'd0, c, r[7], v, r};
  endfunction

  logic [11:0] m0;
  logic [11:0] m1 [3];
  always @(posedge clk) m0 <= alu_ref(alu_a, alu_b, alu_sel);
  always @(posedge clk) begin
    m1[0] <= alu_ref(alu_a1, alu_b1, alu_sel1);
    m1[1] <= m1[0];
    m1[2] <= m1[1];
  end
  assign {alu_z, alu_c, alu_n, alu_v, alu_out} = m0;
  assign {alu_z1, alu_c1, alu_n1, alu_v1, alu_out1} = m1[2];

  alu_cmd_issuer u_dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_op(cmd_op), .cmd_tag(cmd_tag),
    .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
    .alu_out(alu_out), .alu_z(alu_z), .alu_c(alu_c),
    .alu_n(alu_n), .alu_v(alu_v),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_flags(rsp_flags),
    .rsp_tag(rsp_tag), .rsp_err(rsp_err),
    .op_count(op_count), .err_count(err_count)
  );

  alu_cmd_issuer #(.ALU_LAT(3), .CNT_W(8)) u_sat (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid1), .cmd_ready(cmd_ready1),
    .cmd_a(cmd_a1), .cmd_b(cmd_b1), .cmd_op(cmd_op1), .cmd_tag(cmd_tag1),
    .alu_a(alu_a1), .alu_b(alu_b1), .alu_sel(alu_sel1),
    .alu_out(alu_out1), .alu_z(alu_z1), .alu_c(alu_c1),
    .alu_n(alu_n1), .alu_v(alu_v1),
    .rsp_valid(rsp_valid1), .rsp_ready(rsp_ready1),
    .rsp_data(rsp_data1), .rsp_flags(rsp_flags1),
    .rsp_tag(rsp_tag1), .rsp_err(rsp_err1),
    .op_count(op_count1), .err_count(err_count1)
  );

  task automatic issue0(input logic [7:0] a, input logic [7:0] b,
                        input logic [3:0] op, input logic [3:0] tag);
    int t = 0;
    cmd_a = a; cmd_b = b; cmd_op = op; cmd_tag = tag; cmd_valid = 1;
    while (!cmd_ready && t < 20) begin @(posedge clk); #1; t++; end
    n_vec++;
    if (cmd_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL issue_timeout cmd_ready=%b want 1", cmd_ready);
    end
    @(posedge clk); #1;
    cmd_valid = 0;
  endtask

  task automatic drain0(input int exp_lat, input string nm);
    int lat = 0;
    rsp_t got, e;
    while (!rsp_valid && lat < 20) begin @(posedge clk); #1; lat++; end
    n_vec++;
    if (lat != exp_lat) begin
      n_bad++;
      $display("FAIL %s_latency got %0d want %0d", nm, lat, exp_lat);
    end
    got = {rsp_data, rsp_flags, rsp_tag, rsp_err};
    e = (q0.size() != 0) ? q0.pop_front() : '1;
    n_vec++;
    if (got !== e) begin
      n_bad++;
      $display("FAIL %s_rsp got d=%0d f=%b t=%0d e=%b want d=%0d f=%b t=%0d e=%b",
               nm, got.data, got.flags, got.tag, got.err,
               e.data, e.flags, e.tag, e.err);
    end
    rsp_ready = 1; @(posedge clk); #1; rsp_ready = 0;
  endtask

  task automatic test_reset;
    repeat (3) @(posedge clk);
    #1 reset = 0;
    n_vec++;
    if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_hs ready=%b valid=%b want 1 0", cmd_ready, rsp_valid);
    end
    n_vec++;
    if ({alu_a, alu_b, alu_sel} !== 20'd0) begin
      n_bad++;
      $display("FAIL reset_alu got %h want 0", {alu_a, alu_b, alu_sel});
    end
    n_vec++;
    if ({rsp_data, rsp_flags, rsp_tag, rsp_err} !== 17'd0) begin
      n_bad++;
      $display("FAIL reset_rsp got %h want 0", {rsp_data, rsp_flags, rsp_tag, rsp_err});
    end
    n_vec++;
    if (op_count !== 16'd0 || err_count !== 16'd0) begin
      n_bad++;
      $display("FAIL reset_cnt got %0d %0d want 0 0", op_count, err_count);
    end
  endtask

  task automatic test_add;
    issue0(8'd5, 8'd3, OP_ADD, 4'd1);
    q0.push_back('{data: 8'd8, flags: 4'b0000, tag: 4'd1, err: 1'b0});
    drain0(2, "add");
    n_vec++;
    if (op_count !== 16'd1) begin
      n_bad++;
      $display("FAIL add_opcount got %0d want 1", op_count);
    end
  endtask

  task automatic test_flags;
    issue0(8'd125, 8'd3, OP_ADD, 4'd2);
    q0.push_back('{data: 8'd128, flags: 4'b0011, tag: 4'd2, err: 1'b0});
    drain0(2, "add_ovf");
    issue0(8'd5, 8'd13, OP_SUB, 4'd3);
    q0.push_back('{data: 8'd248, flags: 4'b0110, tag: 4'd3, err: 1'b0});
    drain0(2, "sub_neg");
    issue0(8'd5, 8'd5, OP_SUB, 4'd4);
    q0.push_back('{data: 8'd0, flags: 4'b1000, tag: 4'd4, err: 1'b0});
    drain0(2, "sub_zero");
  endtask

  task automatic test_illegal;
    issue0(8'd9, 8'd9, 4'b1010, 4'd7);
    q0.push_back('{data: 8'd0, flags: 4'b0000, tag: 4'd7, err: 1'b1});
    n_vec++;
    if ({alu_a, alu_b, alu_sel} !== {8'd5, 8'd5, 4'b0001}) begin
      n_bad++;
      $display("FAIL illegal_alu got %h want 05051", {alu_a, alu_b, alu_sel});
    end
    drain0(0, "illegal");
    n_vec++;
    if (err_count !== 16'd1 || op_count !== 16'd4) begin
      n_bad++;
      $display("FAIL illegal_cnt got %0d %0d want 1 4", err_count, op_count);
    end
  endtask

  task automatic test_backpressure;
    int lat = 0;
    rsp_t got, e;
    issue0(8'd12, 8'd10, OP_AND, 4'd2);
    q0.push_back('{data: 8'd8, flags: 4'b0000, tag: 4'd2, err: 1'b0});
    while (!rsp_valid && lat < 20) begin @(posedge clk); #1; lat++; end
    cmd_a = 8'd1; cmd_b = 8'd2; cmd_op = OP_OR; cmd_tag = 4'd3; cmd_valid = 1;
    for (int k = 0; k < 5; k++) begin
      n_vec++;
      if (rsp_valid !== 1'b1 || rsp_data !== 8'd8 || cmd_ready !== 1'b0) begin
        n_bad++;
        $display("FAIL bp_hold%0d got v=%b d=%0d r=%b want 1 8 0",
                 k, rsp_valid, rsp_data, cmd_ready);
      end
      @(posedge clk); #1;
    end
    got = {rsp_data, rsp_flags, rsp_tag, rsp_err};
    e = (q0.size() != 0) ? q0.pop_front() : '1;
    n_vec++;
    if (got !== e) begin
      n_bad++;
      $display("FAIL bp_rsp got %h want %h", got, e);
    end
    rsp_ready = 1; @(posedge clk); #1; rsp_ready = 0;
    n_vec++;
    if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL bp_nobypass got v=%b r=%b want 0 1", rsp_valid, cmd_ready);
    end
    @(posedge clk); #1;
    cmd_valid = 0;
    q0.push_back('{data: 8'd3, flags: 4'b0000, tag: 4'd3, err: 1'b0});
    n_vec++;
    if (cmd_ready !== 1'b0 || alu_sel !== OP_OR || alu_a !== 8'd1) begin
      n_bad++;
      $display("FAIL bp_accept got r=%b sel=%b a=%0d want 0 0011 1",
               cmd_ready, alu_sel, alu_a);
    end
    drain0(2, "bp_second");
    n_vec++;
    if (op_count !== 16'd6) begin
      n_bad++;
      $display("FAIL bp_opcount got %0d want 6", op_count);
    end
  endtask

  task automatic test_reset_mid;
    issue0(8'd113, 8'd3, OP_SLL, 4'd5);
    reset = 1; @(posedge clk); #1; reset = 0;
    n_vec++;
    if (cmd_ready !== 1'b1 || {alu_a, alu_b, alu_sel} !== 20'd0) begin
      n_bad++;
      $display("FAIL rst_mid_alu got r=%b %h want 1 0", cmd_ready, {alu_a, alu_b, alu_sel});
    end
    n_vec++;
    if ({rsp_data, rsp_flags, rsp_tag, rsp_err} !== 17'd0 ||
        op_count !== 16'd0 || err_count !== 16'd0) begin
      n_bad++;
      $display("FAIL rst_mid_rsp got %h %0d %0d want 0 0 0",
               {rsp_data, rsp_flags, rsp_tag, rsp_err}, op_count, err_count);
    end
    for (int k = 0; k < 4; k++) begin
      n_vec++;
      if (rsp_valid !== 1'b0) begin
        n_bad++;
        $display("FAIL rst_mid_norsp%0d got %b want 0", k, rsp_valid);
      end
      @(posedge clk); #1;
    end
    issue0(8'd5, 8'd3, OP_ADD, 4'd6);
    q0.push_back('{data: 8'd8, flags: 4'b0000, tag: 4'd6, err: 1'b0});
    drain0(2, "rst_mid_add");
    n_vec++;
    if (op_count !== 16'd1) begin
      n_bad++;
      $display("FAIL rst_mid_opcount got %0d want 1", op_count);
    end
  endtask

  task automatic test_back_to_back;
    for (int i = 0; i < 300; i++) begin
      int t = 0;
      int lat = 0;
      int exp_cnt;
      logic [11:0] r;
      rsp_t got, e;
      cmd_a1 = 8'($urandom);
      cmd_b1 = 8'($urandom);
      cmd_op1 = 4'($urandom_range(0, 8));
      cmd_tag1 = 4'(i);
      cmd_valid1 = 1;
      while (!cmd_ready1 && t < 20) begin @(posedge clk); #1; t++; end
      @(posedge clk); #1;
      r = alu_ref(cmd_a1, cmd_b1, cmd_op1);
      q1.push_back('{data: r[7:0], flags: r[11:8], tag: cmd_tag1, err: 1'b0});
      while (!rsp_valid1 && lat < 20) begin @(posedge clk); #1; lat++; end
      n_vec++;
      if (lat != 4) begin
        n_bad++;
        $display("FAIL b2b_latency op%0d got %0d want 4", i, lat);
      end
      got = {rsp_data1, rsp_flags1, rsp_tag1, rsp_err1};
      e = (q1.size() != 0) ? q1.pop_front() : '1;
      n_vec++;
      if (got !== e) begin
        n_bad++;
        $display("FAIL b2b_rsp op%0d got %h want %h", i, got, e);
      end
      exp_cnt = (i + 1 > 255) ? 255 : i + 1;
      n_vec++;
      if (op_count1 !== 8'(exp_cnt)) begin
        n_bad++;
        $display("FAIL b2b_opcount op%0d got %0d want %0d", i, op_count1, exp_cnt);
      end
    end
    cmd_valid1 = 0;
  endtask

  initial begin
    test_reset();
    test_add();
    test_flags();
    test_illegal();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
